aw_sram_loader: RTL and testbench

//  Writer side of the activation/weight SRAM interface: accepts a 32-bit valid/ready word stream and writes it into ACT SRAM and W SRAM.

---
 rtl/aw_sram_loader.sv | 146 ++++++++++++++
 tb/tb_aw_sram_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aw_sram_loader.sv
// Stream-to-SRAM loader for the ACT/W macros; kicks the corelet once both are full.
// Optional running checksum of accepted words: define LOADER_CHECKSUM_EN.
module aw_sram_loader #(
  parameter int ACT_WORDS = 36,
  parameter int W_ROWS    = 8,
  parameter int NUM_KIJ   = 9,
  parameter int AW        = 7,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] ACT_d,
  output logic [AW-1:0] ACT_addr,
  output logic          ACT_cen,
  output logic          ACT_wen,
  output logic [DW-1:0] W_d,
  output logic [AW-1:0] W_addr,
  output logic          W_cen,
  output logic          W_wen,
  output logic          seq_begin,
  input  logic          seq_done,
  output logic          core_busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  localparam int W_WORDS = NUM_KIJ * W_ROWS;
  localparam logic [AW-1:0] ACT_LAST = AW'(ACT_WORDS - 1);
  localparam logic [AW-1:0] W_LAST   = AW'(W_WORDS - 1);

  if (W_WORDS > (2 ** AW) || ACT_WORDS > (2 ** AW)) begin : g_bad_aw
    $error("aw_sram_loader: AW too small for the word counts");
  end

  // DRAIN covers the registered write of the final W word before seq_begin
  typedef enum logic [2:0] {
    IDLE,
    LOAD_ACT,
    LOAD_W,
    DRAIN,
    START,
    RUN,
    FIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wcnt;
  logic          acc;
  logic          act_wr;
  logic          w_wr;
  logic          last;
  logic          go;

  assign go     = (state == IDLE) & start;
  assign acc    = in_valid & in_ready;
  assign act_wr = acc & (state == LOAD_ACT);
  assign w_wr   = acc & (state == LOAD_W);
  assign last   = (state == LOAD_ACT) ? (wcnt == ACT_LAST)
                                      : (wcnt == W_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = LOAD_ACT;
      LOAD_ACT: if (act_wr && last) state_nxt = LOAD_W;
      LOAD_W:   if (w_wr && last) state_nxt = DRAIN;
      DRAIN:    state_nxt = START;
      START:    state_nxt = RUN;
      RUN:      if (seq_done) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    seq_begin = 1'b0;
    core_busy = 1'b0;
    done      = 1'b0;
    unique case (state)
      LOAD_ACT,
      LOAD_W:  in_ready = 1'b1;
      START: begin
        seq_begin = 1'b1;
        core_busy = 1'b1;
      end
      RUN:     core_busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   wcnt <= '0;
    else if (go) wcnt <= '0;
    else if (acc) wcnt <= last ? '0 : wcnt + 1'b1;
  end

  // SRAM ports: one registered write per accepted beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ACT_cen  <= 1'b1;
      ACT_wen  <= 1'b1;
      ACT_addr <= '0;
      ACT_d    <= '0;
      W_cen    <= 1'b1;
      W_wen    <= 1'b1;
      W_addr   <= '0;
      W_d      <= '0;
    end else begin
      ACT_cen <= ~act_wr;
      ACT_wen <= ~act_wr;
      W_cen   <= ~w_wr;
      W_wen   <= ~w_wr;
      if (act_wr) begin
        ACT_addr <= wcnt;
        ACT_d    <= in_data;
      end
      if (w_wr) begin
        W_addr <= wcnt;
        W_d    <= in_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    checksum <= '0;
    else if (go)  checksum <= '0;
    else if (acc) checksum <= checksum + in_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_aw_sram_loader.sv
// Randomized bench for aw_sram_loader against a transaction-level model.
// Build with LOADER_CHECKSUM_EN to check the checksum option.
module tb_aw_sram_loader;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int NA = 36;
  localparam int NW = 108;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_WAIT  = 2;
  localparam int P_BEGIN = 3;
  localparam int P_RUN   = 4;
  localparam int P_FIN   = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          seq_done = 1'b0;
  logic          in_ready;
  logic [DW-1:0] ACT_d;
  logic [AW-1:0] ACT_addr;
  logic          ACT_cen;
  logic          ACT_wen;
  logic [DW-1:0] W_d;
  logic [AW-1:0] W_addr;
  logic          W_cen;
  logic          W_wen;
  logic          seq_begin;
  logic          core_busy;
  logic          done;
  logic [DW-1:0] checksum;

  aw_sram_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ACT_d(ACT_d), .ACT_addr(ACT_addr),
    .ACT_cen(ACT_cen), .ACT_wen(ACT_wen),
    .W_d(W_d), .W_addr(W_addr), .W_cen(W_cen), .W_wen(W_wen),
    .seq_begin(seq_begin), .seq_done(seq_done),
    .core_busy(core_busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level model: phase + accepted-word count
  int          ph = P_IDLE;
  int          n = 0;
  logic [31:0] sum = '0;
  logic        ea_we = 1'b0;
  logic        ew_we = 1'b0;
  logic [6:0]  ea_addr = '0;
  logic [6:0]  ew_addr = '0;
  logic [31:0] ea_d = '0;
  logic [31:0] ew_d = '0;
  int          cyc = 0;
  int          act_writes = 0;
  int          w_writes = 0;
  int          lastw_cyc = 0;
  int          sb_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      ph = P_IDLE; n = 0; sum = '0;
      ea_we = 1'b0; ew_we = 1'b0;
    end
    chk("in_ready", 32'(in_ready), 32'(ph == P_LOAD));
    chk("act_cen", 32'(ACT_cen), 32'(!ea_we));
    chk("act_wen", 32'(ACT_wen), 32'(!ea_we));
    chk("w_cen", 32'(W_cen), 32'(!ew_we));
    chk("w_wen", 32'(W_wen), 32'(!ew_we));
    if (ea_we) begin
      chk("act_addr", 32'(ACT_addr), 32'(ea_addr));
      chk("act_d", ACT_d, ea_d);
    end
    if (ew_we) begin
      chk("w_addr", 32'(W_addr), 32'(ew_addr));
      chk("w_d", W_d, ew_d);
    end
    if (!ACT_cen) act_writes++;
    if (!W_cen) begin
      w_writes++;
      lastw_cyc = cyc;
    end
    if (seq_begin) sb_cyc = cyc;
    chk("seq_begin", 32'(seq_begin), 32'(ph == P_BEGIN));
    chk("core_busy", 32'(core_busy), 32'(ph == P_BEGIN || ph == P_RUN));
    chk("done", 32'(done), 32'(ph == P_FIN));
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", checksum, sum);
`else
    chk("checksum", checksum, 32'd0);
`endif
    // advance the model by the inputs that the next rising edge samples
    if (!reset) begin
      ea_we = 1'b0;
      ew_we = 1'b0;
      case (ph)
        P_IDLE: if (start) begin
          ph = P_LOAD; n = 0; sum = '0;
        end
        P_LOAD: if (in_valid) begin
          if (n < NA) begin
            ea_we = 1'b1; ea_addr = 7'(n); ea_d = in_data;
          end else begin
            ew_we = 1'b1; ew_addr = 7'(n - NA); ew_d = in_data;
          end
          sum = sum + in_data;
          n++;
          if (n == NW) ph = P_WAIT;
        end
        P_WAIT:  ph = P_BEGIN;
        P_BEGIN: ph = P_RUN;
        P_RUN:   if (seq_done) ph = P_FIN;
        P_FIN:   ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
    cyc++;
  end

  task automatic chk_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_act_cen", 32'(ACT_cen), 32'd1);
    chk("rst_act_wen", 32'(ACT_wen), 32'd1);
    chk("rst_act_addr", 32'(ACT_addr), 32'd0);
    chk("rst_act_d", ACT_d, 32'd0);
    chk("rst_w_cen", 32'(W_cen), 32'd1);
    chk("rst_w_wen", 32'(W_wen), 32'd1);
    chk("rst_w_addr", 32'(W_addr), 32'd0);
    chk("rst_w_d", W_d, 32'd0);
    chk("rst_seq_begin", 32'(seq_begin), 32'd0);
    chk("rst_core_busy", 32'(core_busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
  endtask

  task automatic run_seq(input int gap, input bit rnd, input int hold,
                         input bit noise, input int abort_at);
    int   k;
    int   guard;
    logic r;
    bit   found;
    k = 0;
    guard = 0;
    @(posedge clk) #1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    while (k < NW && guard < 5000) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = rnd ? $urandom : 32'(k);
      if (noise) begin
        start    = 1'($urandom_range(1));
        seq_done = 1'($urandom_range(1));
      end
      @(negedge clk) r = in_ready;
      @(posedge clk) #1;
      if (in_valid && r) k++;
      guard++;
      if (abort_at > 0 && k == abort_at) break;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    seq_done = 1'b0;
    if (abort_at > 0) begin
      reset = 1'b1;
      #1 chk_reset_vals();
      @(posedge clk) #1;
      reset = 1'b0;
      return;
    end
    chk("load_complete", 32'(k), 32'(NW));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (seq_begin) found = 1'b1;
    end
    chk("seq_begin_seen", 32'(found), 32'd1);
    repeat (hold) @(posedge clk) #1;
    @(posedge clk) #1;
    seq_done = 1'b1;
    @(posedge clk) #1;
    seq_done = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        if (!rnd) begin
`ifdef LOADER_CHECKSUM_EN
          chk("checksum_at_done", checksum, 32'd5778);
`else
          chk("checksum_at_done", checksum, 32'd0);
`endif
        end
      end
    end
    chk("done_seen", 32'(found), 32'd1);
    repeat (3) @(posedge clk) #1;
  endtask

  task automatic run_counted(input int gap, input bit rnd, input int hold,
                             input bit noise);
    int a0;
    int w0;
    a0 = act_writes;
    w0 = w_writes;
    run_seq(gap, rnd, hold, noise, 0);
    chk("act_write_count", 32'(act_writes - a0), 32'd36);
    chk("w_write_count", 32'(w_writes - w0), 32'd72);
    chk("seq_begin_after_last_w", 32'(sb_cyc - lastw_cyc), 32'd1);
  endtask

  initial begin
    #12 chk_reset_vals();
    @(posedge clk) #1;
    reset = 1'b0;
    repeat (2) @(posedge clk) #1;
    run_counted(0, 1'b0, 3, 1'b0);
    run_counted(50, 1'b1, 5, 1'b0);
    run_counted(30, 1'b1, 500, 1'b0);
    run_counted(20, 1'b0, 2, 1'b1);
    run_seq(0, 1'b0, 0, 1'b0, 20);
    repeat (2) @(posedge clk) #1;
    run_counted(10, 1'b0, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
